regfile_bypass: RTL and testbench
=================================

REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 Parameter WIDTH, default 16: data width of each register and of every data port.
REQ-002 Parameter BYPASS, default 1: 1 = write-before-read forwarding enabled; 0 = reads return stored contents only.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port read1RegSel  input  3  register index for read port 1.
REQ-006 Port read2RegSel  input  3  register index for read port 2.
REQ-007 Port writeRegSel  input  3  register index for the write port.
REQ-008 Port writeData  input  WIDTH  data to write.
REQ-009 Port writeEn  input  1  write enable, sampled on rising clk.
REQ-010 Port read1Data  output  WIDTH  read port 1 data, combinational.
REQ-011 Port read2Data  output  WIDTH  read port 2 data, combinational.
REQ-012 Port lastWrSel  output  3  index of most recent committed write, registered.
REQ-013 Port wrCount  output  8  count of committed writes since reset, registered.

Function
REQ-014 Block SHALL hold eight WIDTH-bit registers R0..R7; R0 is an ordinary writable register (no hardwired zero).
REQ-015 On rising clk with writeEn=1, R[writeRegSel] SHALL take writeData; all other registers SHALL hold.
REQ-016 With writeEn=0, no register, lastWrSel or wrCount SHALL change.
REQ-017 Read ports SHALL be independent 8:1 selections per bit: readNData = R[readNRegSel], zero cycles latency, no clock involvement.
REQ-018 Both read ports MAY select the same register simultaneously; both SHALL return identical data.
REQ-019 BYPASS=1: if writeEn=1 and writeRegSel equals readNRegSel, readNData SHALL equal writeData in that same cycle, before the edge.
REQ-020 BYPASS=0: readNData SHALL show the old value until the edge, then the new value.
REQ-021 Bypass SHALL apply per port independently; a port whose selection differs from writeRegSel SHALL be unaffected.
REQ-022 lastWrSel SHALL load writeRegSel on each committed write.
REQ-023 wrCount SHALL increment by 1 on each committed write, wrapping modulo 256 (255 -> 0), with no saturation and no flag.
REQ-024 Writing the value a register already holds SHALL still count as a committed write.
REQ-025 No combinational path SHALL exist from writeData/writeEn to read outputs when BYPASS=0.

Reset
REQ-026 rst_n=0 SHALL, immediately and independently of clk, clear R0..R7, lastWrSel and wrCount to 0.
REQ-027 While rst_n=0, writes SHALL be ignored; read outputs SHALL return 0, or writeData on a bypass match when BYPASS=1.
REQ-028 Reset asserted mid-cycle with writeEn=1 SHALL discard that write; the first write honoured is at the first rising edge with rst_n=1.
REQ-029 Reset deassertion SHALL NOT itself cause a write or a counter increment.

Verification
REQ-030 Reset, then read all eight indices on both ports -> every read = 0x0000, wrCount=0, lastWrSel=0.
REQ-031 Write R3=0xBEEF, R5=0x1234 on consecutive edges; read1Sel=3, read2Sel=5 -> 0xBEEF / 0x1234, wrCount=2, lastWrSel=5.
REQ-032 BYPASS=1, R2=0x0001 stored; drive writeEn=1, writeRegSel=2, writeData=0xA5A5, read1Sel=2, read2Sel=4 before edge -> read1Data=0xA5A5, read2Data=R4 unchanged. BYPASS=0, same stimulus -> read1Data=0x0001 until edge, 0xA5A5 after.
REQ-033 256 back-to-back writes from reset -> wrCount returns to 0; 257th write -> wrCount=1.
REQ-034 Assert rst_n=0 between edges while writeEn=1, writeRegSel=7, writeData=0xFFFF -> R7=0 after release, wrCount=0, all outputs 0 at once without a clock edge.
REQ-035 writeEn=0 with arbitrary writeRegSel/writeData for 10 cycles -> all registers, lastWrSel and wrCount unchanged.

Source files
------------

// File: rtl/regfile_bypass.sv
// Eight-entry register file with two combinational read ports and one write port.
// Optional write-before-read forwarding; tracks the last written index and a write count.
module regfile_bypass #(
    parameter int WIDTH  = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       read1RegSel,
    input  logic [2:0]       read2RegSel,
    input  logic [2:0]       writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    input  logic             writeEn,
    output logic [WIDTH-1:0] read1Data,
    output logic [WIDTH-1:0] read2Data,
    output logic [2:0]       lastWrSel,
    output logic [7:0]       wrCount
);

    logic [WIDTH-1:0] regs [8];
    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            lastWrSel <= '0;
            wrCount   <= '0;
        end else if (writeEn) begin
            regs[writeRegSel] <= writeData;
            lastWrSel         <= writeRegSel;
            wrCount           <= wrCount + 8'd1;
        end
    end

    assign stored1 = regs[read1RegSel];
    assign stored2 = regs[read2RegSel];

    // Forwarding is elaborated away entirely when disabled, so no path from
    // writeData/writeEn to the read ports exists in that build.
    generate
        if (BYPASS) begin : g_bypass
            logic hit1;
            logic hit2;

            assign hit1 = writeEn && (writeRegSel == read1RegSel);
            assign hit2 = writeEn && (writeRegSel == read2RegSel);

            always_comb begin
                read1Data = hit1 ? writeData : stored1;
                read2Data = hit2 ? writeData : stored2;
            end
        end else begin : g_plain
            always_comb begin
                read1Data = stored1;
                read2Data = stored2;
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: a forwarding and a non-forwarding instance share stimulus
// and are checked every cycle against an array model, plus literal spot checks.
module tb_regfile_bypass;

    logic        clk;
    logic        rst_n;
    logic [2:0]  r1s;
    logic [2:0]  r2s;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic        we;

    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic [2:0]  a_last, b_last;
    logic [7:0]  a_cnt, b_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [15:0] m_mem [8];
    int          m_cnt;
    int          m_last;

    regfile_bypass #(.WIDTH(16), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n),
        .read1RegSel(r1s), .read2RegSel(r2s), .writeRegSel(ws),
        .writeData(wd), .writeEn(we),
        .read1Data(a_rd1), .read2Data(a_rd2),
        .lastWrSel(a_last), .wrCount(a_cnt)
    );

    regfile_bypass #(.WIDTH(16), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .rst_n(rst_n),
        .read1RegSel(r1s), .read2RegSel(r2s), .writeRegSel(ws),
        .writeData(wd), .writeEn(we),
        .read1Data(b_rd1), .read2Data(b_rd2),
        .lastWrSel(b_last), .wrCount(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [2:0] s, input bit byp);
        if (byp && we && ws == s) return wd;
        return m_mem[s];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
        m_cnt  = 0;
        m_last = 0;
    endtask

    task automatic drive(input logic e, input logic [2:0] s, input logic [15:0] d,
                         input logic [2:0] a, input logic [2:0] b);
        we = e; ws = s; wd = d; r1s = a; r2s = b;
    endtask

    // Advance one rising edge and commit the write the inputs described.
    task automatic tick();
        @(posedge clk);
        #1;
        if (we && rst_n) begin
            m_mem[ws] = wd;
            m_last    = ws;
            m_cnt     = (m_cnt + 1) % 256;
        end
    endtask

    task automatic cycle(input logic e, input logic [2:0] s, input logic [15:0] d,
                         input logic [2:0] a, input logic [2:0] b);
        drive(e, s, d, a, b);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #3;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("byp_rd1",  a_rd1,  exp_rd(r1s, 1'b1));
            chk("byp_rd2",  a_rd2,  exp_rd(r2s, 1'b1));
            chk("nob_rd1",  b_rd1,  exp_rd(r1s, 1'b0));
            chk("nob_rd2",  b_rd2,  exp_rd(r2s, 1'b0));
            chk("byp_last", a_last, m_last);
            chk("nob_last", b_last, m_last);
            chk("byp_cnt",  a_cnt,  m_cnt);
            chk("nob_cnt",  b_cnt,  m_cnt);
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Reset state: every index on both ports reads zero.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i));
            #2;
            chk("rst_rd1", a_rd1, 16'h0000);
            chk("rst_rd2", b_rd2, 16'h0000);
            tick();
        end
        chk("rst_cnt",  a_cnt,  8'd0);
        chk("rst_last", b_last, 3'd0);

        // Two consecutive writes then read back.
        cycle(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd5);
        cycle(1'b1, 3'd5, 16'h1234, 3'd3, 3'd5);
        drive(1'b0, 3'd0, 16'h0000, 3'd3, 3'd5);
        #2;
        chk("wr2_rd1",  b_rd1,  16'hBEEF);
        chk("wr2_rd2",  a_rd2,  16'h1234);
        chk("wr2_cnt",  a_cnt,  8'd2);
        chk("wr2_last", b_last, 3'd5);
        tick();

        // Forwarding versus stored-only behaviour.
        cycle(1'b1, 3'd2, 16'h0001, 3'd0, 3'd1);
        cycle(1'b1, 3'd4, 16'h4444, 3'd0, 3'd1);
        drive(1'b1, 3'd2, 16'hA5A5, 3'd2, 3'd4);
        #2;
        chk("byp_hit",   a_rd1, 16'hA5A5);
        chk("byp_other", a_rd2, 16'h4444);
        chk("nob_old",   b_rd1, 16'h0001);
        tick();
        drive(1'b0, 3'd0, 16'h0000, 3'd2, 3'd2);
        #2;
        chk("nob_new",   b_rd1, 16'hA5A5);
        chk("same_sel",  a_rd2, 16'hA5A5);
        tick();

        // Rewriting an identical value still counts.
        cycle(1'b1, 3'd2, 16'hA5A5, 3'd2, 3'd6);
        chk("same_val_cnt", a_cnt, 8'd6);

        // Idle cycles with arbitrary select/data.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 3'(i % 8), 3'((i + 3) % 8));
        end
        chk("idle_cnt",  b_cnt,  8'd6);
        chk("idle_last", a_last, 3'd2);

        // Counter wrap after 256 writes from reset.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 3'(i % 8), 16'(i * 3), 3'(i % 8), 3'((i + 1) % 8));
        end
        chk("wrap_cnt",  a_cnt,  8'd0);
        chk("wrap_last", b_last, 3'd7);
        cycle(1'b1, 3'd1, 16'h0101, 3'd1, 3'd7);
        chk("wrap_cnt1", b_cnt, 8'd1);
        chk("wrap_r7",   a_rd2, 16'd765);

        // Asynchronous reset mid-cycle with a pending write.
        drive(1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd1);
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst_cnt",  a_cnt,  8'd0);
        chk("arst_last", b_last, 3'd0);
        chk("arst_nob",  b_rd1,  16'h0000);
        chk("arst_byp",  a_rd1,  16'hFFFF);
        chk("arst_rd2",  a_rd2,  16'h0000);
        tick();
        drive(1'b0, 3'd7, 16'hFFFF, 3'd7, 3'd1);
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst_r7",    a_rd1, 16'h0000);
        chk("arst_cnt2",  b_cnt, 8'd0);
        cycle(1'b1, 3'd7, 16'h7777, 3'd7, 3'd0);
        chk("post_rst_wr", b_rd1, 16'h7777);
        chk("post_rst_cnt", a_cnt, 8'd1);

        tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
